// File: rtl/adder_sweep_ctrl_if.sv
// adder_sweep_ctrl_if: operand/result/status bundle between the sweep controller and its user
interface adder_sweep_ctrl_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] term_1;
  logic [WIDTH-1:0] term_2;
  logic [WIDTH:0] sum_in;
  logic busy;
  logic done;
  logic [2*WIDTH:0] err_count;
  logic first_err_valid;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic [WIDTH:0] first_err_sum;
  modport slave (
    input start, sum_in,
    output term_1, term_2, busy, done, err_count, first_err_valid, first_err_a, first_err_b, first_err_sum
  );
  modport master (
    output start, sum_in,
    input term_1, term_2, busy, done, err_count, first_err_valid, first_err_a, first_err_b, first_err_sum
  );
endinterface

// File: rtl/adder_sweep_ctrl.sv
// adder_sweep_ctrl: exhaustive adder sweep and check; ADDER_SWEEP_STOP_ON_ERR_EN stops on first mismatch
module adder_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  adder_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  state_t state, nxt;
  logic [WIDTH-1:0] a, b, fa, fb;
  logic [WIDTH:0] fs, golden;
  logic [7:0] cnt;
  logic [2*WIDTH:0] errs;
  logic fev, mismatch, last, accept, stop;
  assign golden = {1'b0, a} + {1'b0, b};
  assign mismatch = bus.sum_in != golden;
  assign last = &{a, b};
  assign accept = bus.start && (state == IDLE || state == DONE);
`ifdef ADDER_SWEEP_STOP_ON_ERR_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: starts are only honoured when idle or done
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = accept ? SETTLE : state;
      SETTLE: nxt = cnt == 8'd0 ? CHECK : SETTLE;
      default: nxt = (last || stop) ? DONE : SETTLE;
    endcase
  end
  // operands, settle counter and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      cnt <= '0;
      errs <= '0;
      fev <= 1'b0;
      fa <= '0;
      fb <= '0;
      fs <= '0;
    end else if (accept) begin
      a <= '0;
      b <= '0;
      cnt <= RELOAD;
      errs <= '0;
      fev <= 1'b0;
      fa <= '0;
      fb <= '0;
      fs <= '0;
    end else if (state == SETTLE) begin
      cnt <= cnt - 8'd1;
    end else if (state == CHECK) begin
      if (mismatch) begin
        errs <= errs + (2*WIDTH+1)'(1);
        if (!fev) begin
          fev <= 1'b1;
          fa <= a;
          fb <= b;
          fs <= bus.sum_in;
        end
      end
      if (nxt == SETTLE) begin
        {a, b} <= {a, b} + (2*WIDTH)'(1);
        cnt <= RELOAD;
      end
    end
  end
  assign bus.term_1 = a;
  assign bus.term_2 = b;
  assign bus.busy = state == SETTLE || state == CHECK;
  assign bus.done = state == DONE;
  assign bus.err_count = errs;
  assign bus.first_err_valid = fev;
  assign bus.first_err_a = fa;
  assign bus.first_err_b = fb;
  assign bus.first_err_sum = fs;
endmodule

// File: doc/adder_sweep_ctrl.md
Name: adder_sweep_ctrl

Overview:
- Sequential stimulus/check stage that sits directly upstream of the ripple-carry adder.
- Drives the adder's two operand inputs through every operand pair, waits a programmable settle time, then samples the adder's sum.
- Compares the sample against an internal golden a+b and reports the mismatch count plus the first failing pair.
- Used for exhaustive functional and delay-margin analysis of adder variants.

Parameters:
- WIDTH, 4, operand width in bits; sum width is WIDTH+1.
- SETTLE_CYCLES, 2, clock cycles the operands are held before the sample cycle; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- term_1  output  WIDTH  operand A to the adder; registered.
- term_2  output  WIDTH  operand B to the adder; registered.
- sum_in  input  WIDTH+1  adder result.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- err_count  output  2*WIDTH+1  number of mismatching pairs.
- first_err_valid  output  1  at least one mismatch recorded.
- first_err_a  output  WIDTH  term_1 of the first mismatch.
- first_err_b  output  WIDTH  term_2 of the first mismatch.
- first_err_sum  output  WIDTH+1  sum_in captured at the first mismatch.

Behaviour:
- Reset:
  - Asynchronous, takes effect immediately, including mid-sweep.
  - State goes to IDLE; every output is 0.
  - A sweep interrupted by reset is abandoned, not resumed.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge loads term_1=0, term_2=0, settle counter=SETTLE_CYCLES-1, clears err_count and all first_err_* outputs, then goes to SETTLE.
- SETTLE:
  - busy=1; operands held.
  - Counter decrements each cycle.
  - At counter==0 the FSM goes to CHECK, so operands are stable for exactly SETTLE_CYCLES cycles before CHECK.
- CHECK (one cycle):
  - Golden = {1'b0,term_1} + {1'b0,term_2}, computed at WIDTH+1 bits, no truncation.
  - sum_in is sampled at the edge ending CHECK.
  - On mismatch: err_count increments. If first_err_valid=0, first_err_a/b/sum capture the current term_1/term_2/sum_in and first_err_valid sets.
  - Operand advance, when this is not the final pair: term_2 increments; when term_2 wraps from all-ones to 0, term_1 also increments. Settle counter reloads; next state is SETTLE.
  - Final pair (term_1 and term_2 both all-ones): next state is DONE.
- DONE:
  - busy=0, done=1.
  - term_1/term_2 hold the last pair; results hold.
  - start=1 restarts exactly as from IDLE (done drops on the same edge that raises busy).
- Timing:
  - Each pair takes SETTLE_CYCLES+1 cycles.
  - If start is accepted at edge E0, done is first visible after edge E0 + 2^(2*WIDTH)*(SETTLE_CYCLES+1), i.e. 768 cycles for the defaults.
- start while busy=1 is ignored; it has no effect on counters or operands.
- err_count cannot overflow: its maximum is 2^(2*WIDTH), so no saturation logic is needed.
- sum_in is treated as combinational from term_1/term_2. The block adds no input register beyond the CHECK sample.

Optional Feature:
- Macro ADDER_SWEEP_STOP_ON_ERR_EN.
- Defined: on the first mismatch, CHECK goes directly to DONE; err_count=1; term_1/term_2 freeze on the failing pair.
- Undefined: the full sweep always runs to completion, counting every mismatch.

Test Plan:
- Ideal behavioural adder on sum_in, defaults, start pulse -> done rises 768 cycles after the start edge; err_count=0; first_err_valid=0; term_1=term_2=4'hF.
- Adder model with sum[0] stuck at 0 -> err_count=128; first_err_a=0, first_err_b=1, first_err_sum=5'b00000.
- Adder model with carry-out (sum[4]) stuck at 0 -> err_count=120; first_err_a=1, first_err_b=15, first_err_sum=5'b00000.
- Ideal adder, rst pulsed 100 cycles after start -> all outputs 0 immediately, without waiting for a clock edge. A new start then sweeps from pair (0,0), and done arrives 768 cycles later with err_count=0.
- Extra start pulses during busy -> no change to operand sequence or completion time. start in DONE -> done=0, busy=1, err_count cleared, sweep restarts at (0,0).
- ADDER_SWEEP_STOP_ON_ERR_EN defined, sum[0] stuck at 0 -> done after pair (0,1), i.e. 6 cycles after the start edge; err_count=1; term_1=0, term_2=1.
